// File: rtl/alu_operand_bypass_if.sv
// alu_operand_bypass_if -- bundle of the decode issue port, the three
// forwarding sources and the registered ALU operand port.
//   slave  : used by alu_operand_bypass
//   master : used by the decode/ALU side (or a testbench)
// Parameters: DW word width, RW register index width.
interface alu_operand_bypass_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  // decode issue
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] ina;
  logic [DW-1:0] inb;
  logic          cin;
  logic [DW-1:0] cr;
  logic [RW-1:0] ra_idx;
  logic [RW-1:0] rb_idx;
  logic          ra_use;
  logic          rb_use;
  logic [RW-1:0] rt_idx;
  logic          rt_write;
  logic          is_load;
  // forwarding sources
  logic          ex_valid;
  logic [RW-1:0] ex_idx;
  logic [DW-1:0] ex_data;
  logic          wb_valid;
  logic [RW-1:0] wb_idx;
  logic [DW-1:0] wb_data;
  logic          ld_valid;
  logic [RW-1:0] ld_idx;
  logic [DW-1:0] ld_data;
  // ALU side
  logic [DW-1:0] outa;
  logic [DW-1:0] outb;
  logic          cin_o;
  logic [DW-1:0] cr_o;
  logic          alu_valid;
  logic          alu_ready;
  logic [15:0]   stall_cnt;

  modport slave (
    input  dec_valid, ina, inb, cin, cr, ra_idx, rb_idx, ra_use, rb_use,
           rt_idx, rt_write, is_load,
           ex_valid, ex_idx, ex_data, wb_valid, wb_idx, wb_data,
           ld_valid, ld_idx, ld_data, alu_ready,
    output dec_ready, outa, outb, cin_o, cr_o, alu_valid, stall_cnt
  );

  modport master (
    output dec_valid, ina, inb, cin, cr, ra_idx, rb_idx, ra_use, rb_use,
           rt_idx, rt_write, is_load,
           ex_valid, ex_idx, ex_data, wb_valid, wb_idx, wb_data,
           ld_valid, ld_idx, ld_data, alu_ready,
    input  dec_ready, outa, outb, cin_o, cr_o, alu_valid, stall_cnt
  );
endinterface

// File: rtl/alu_operand_bypass.sv
// alu_operand_bypass -- operand bypass and load-use interlock in front of
// the ALU. Picks each source operand from the newest in-flight producer,
// stalls decode while an operand waits on an outstanding load, and holds
// one registered operand set for the ALU under a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : alu_operand_bypass_if.slave (decode, ex/wb/ld sources, ALU side)
// Build option: define ALU_BYPASS_WB_FWD_EN to forward from the wb source
//   (priority ex > wb > ld > decode); otherwise wb_* is ignored
//   (priority ex > ld > decode).
module alu_operand_bypass #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_operand_bypass_if.slave  bus
);
  localparam int NREG = 1 << RW;

  logic [NREG-1:0] pend, pend_nxt;
  logic            live_a, live_b, hazard, issue;
  logic [DW-1:0]   opa, opb;

  logic          ex_valid, ld_valid;
  logic [RW-1:0] ex_idx, ld_idx;
  logic [DW-1:0] ex_data, ld_data;
  assign ex_valid = bus.ex_valid;
  assign ex_idx   = bus.ex_idx;
  assign ex_data  = bus.ex_data;
  assign ld_valid = bus.ld_valid;
  assign ld_idx   = bus.ld_idx;
  assign ld_data  = bus.ld_data;

`ifdef ALU_BYPASS_WB_FWD_EN
  logic          wb_valid;
  logic [RW-1:0] wb_idx;
  logic [DW-1:0] wb_data;
  assign wb_valid = bus.wb_valid;
  assign wb_idx   = bus.wb_idx;
  assign wb_data  = bus.wb_data;
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_idx, bus.wb_data};
`endif

  // Newest producer wins; r0 and unused operands keep the file value.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx,
                                        input logic use_op,
                                        input logic [DW-1:0] dec);
    fwd = dec;
    if (use_op && idx != '0) begin
      if (ex_valid && ex_idx == idx)      fwd = ex_data;
`ifdef ALU_BYPASS_WB_FWD_EN
      else if (wb_valid && wb_idx == idx) fwd = wb_data;
`endif
      else if (ld_valid && ld_idx == idx) fwd = ld_data;
    end
  endfunction

  // A load returning this cycle no longer blocks its consumer.
  assign live_a = pend[bus.ra_idx] && !(ld_valid && ld_idx == bus.ra_idx);
  assign live_b = pend[bus.rb_idx] && !(ld_valid && ld_idx == bus.rb_idx);
  assign hazard = (bus.ra_use && bus.ra_idx != '0 && live_a) ||
                  (bus.rb_use && bus.rb_idx != '0 && live_b);

  assign bus.dec_ready = (!bus.alu_valid || bus.alu_ready) && !hazard;
  assign issue         = bus.dec_valid && bus.dec_ready;

  assign opa = fwd(bus.ra_idx, bus.ra_use, bus.ina);
  assign opb = fwd(bus.rb_idx, bus.rb_use, bus.inb);

  // Clear first so a same-cycle set on the same index wins.
  always_comb begin
    pend_nxt = pend;
    if (ld_valid) pend_nxt[ld_idx] = 1'b0;
    if (issue && bus.is_load && bus.rt_write && bus.rt_idx != '0)
      pend_nxt[bus.rt_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend          <= '0;
      bus.alu_valid <= 1'b0;
      bus.outa      <= '0;
      bus.outb      <= '0;
      bus.cin_o     <= 1'b0;
      bus.cr_o      <= '0;
      bus.stall_cnt <= '0;
    end else begin
      pend <= pend_nxt;
      if (issue) begin
        bus.alu_valid <= 1'b1;
        bus.outa      <= opa;
        bus.outb      <= opb;
        bus.cin_o     <= bus.cin;
        bus.cr_o      <= bus.cr;
      end else if (bus.alu_ready) begin
        bus.alu_valid <= 1'b0;
      end
      // Only load-use stalls count; ALU back-pressure does not.
      if (bus.dec_valid && hazard && bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end
  end
endmodule
